// File: rtl/divider_seq.sv
// Sequential restoring divider: WIDTH steps per operation, signed or unsigned operands,
// truncating signed semantics, divide-by-zero bypass with a fixed all-ones quotient.
module divider_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] divMag_q, divMag_d;
  logic [WIDTH-1:0] dividend_q, dividend_d;
  logic             qNeg_q, qNeg_d;
  logic             rNeg_q, rNeg_d;
  logic             bZero_q, bZero_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             divZero_q, divZero_d;
  logic             done_q, done_d;

  logic             aNeg, bNeg;
  logic [WIDTH-1:0] aMag, bMag;
  logic [WIDTH-1:0] quoFix, remFix;
  logic [WIDTH:0]   remShift;
  logic [WIDTH+1:0] diff;

  // The shifted partial remainder needs one extra bit; the top bit of diff is the borrow.
  always_comb begin
    aNeg     = signed_mode & a[WIDTH-1];
    bNeg     = signed_mode & b[WIDTH-1];
    aMag     = aNeg ? -a : a;
    bMag     = bNeg ? -b : b;
    remShift = {rem_q, quo_q[WIDTH-1]};
    diff     = {1'b0, remShift} - {2'b00, divMag_q};
    quoFix   = qNeg_q ? -quo_q : quo_q;
    remFix   = rNeg_q ? -rem_q : rem_q;
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    divMag_d   = divMag_q;
    dividend_d = dividend_q;
    qNeg_d     = qNeg_q;
    rNeg_d     = rNeg_q;
    bZero_d    = bZero_q;
    q_d        = q_q;
    r_d        = r_q;
    divZero_d  = divZero_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          dividend_d = a;
          quo_d      = aMag;
          divMag_d   = bMag;
          rem_d      = '0;
          qNeg_d     = aNeg ^ bNeg;
          rNeg_d     = aNeg;
          bZero_d    = (b == '0);
          count_d    = CW'(WIDTH);
          state_d    = (b == '0) ? FIX : RUN;
        end
      end
      RUN: begin
        if (diff[WIDTH+1]) begin
          rem_d = WIDTH'(remShift);
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end else begin
          rem_d = WIDTH'(diff);
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end
        count_d = count_q - CW'(1);
        if (count_q == CW'(1)) state_d = FIX;
      end
      FIX: begin
        q_d       = bZero_q ? '1 : quoFix;
        r_d       = bZero_q ? dividend_q : remFix;
        divZero_d = bZero_q;
        done_d    = 1'b1;
        count_d   = '0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      count_q    <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      divMag_q   <= '0;
      dividend_q <= '0;
      qNeg_q     <= 1'b0;
      rNeg_q     <= 1'b0;
      bZero_q    <= 1'b0;
      q_q        <= '0;
      r_q        <= '0;
      divZero_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      divMag_q   <= divMag_d;
      dividend_q <= dividend_d;
      qNeg_q     <= qNeg_d;
      rNeg_q     <= rNeg_d;
      bZero_q    <= bZero_d;
      q_q        <= q_d;
      r_q        <= r_d;
      divZero_q  <= divZero_d;
      done_q     <= done_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign q        = q_q;
  assign r        = r_q;
  assign div_zero = divZero_q;

endmodule

// File: tb/tb_divider_seq.sv
// Self-checking bench for divider_seq: a latency/arithmetic reference model compared every
// cycle on a 32-bit instance, plus hand-computed directed cases on 32- and 8-bit instances.
module tb_divider_seq;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic         signed_mode = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, div_zero;
  logic [W-1:0] q, r;

  logic         start8 = 1'b0;
  logic         sm8 = 1'b0;
  logic [7:0]   a8 = '0;
  logic [7:0]   b8 = '0;
  logic         busy8, done8, dz8;
  logic [7:0]   q8, r8;

  int vecCount = 0;
  int missCount = 0;
  int edgeCnt = 0;
  int startEdge = 0;
  logic checkEn = 1'b0;

  logic         mBusy = 1'b0;
  logic         mDone = 1'b0;
  logic         mDz = 1'b0;
  logic [W-1:0] mQ = '0;
  logic [W-1:0] mR = '0;
  int           mLeft = 0;
  logic [64:0]  pending = '0;

  divider_seq #(.WIDTH(W)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .signed_mode(signed_mode),
    .a(a), .b(b), .busy(busy), .done(done), .q(q), .r(r), .div_zero(div_zero)
  );

  divider_seq #(.WIDTH(8)) dut8 (
    .clock(clock), .reset_n(reset_n), .start(start8), .signed_mode(sm8),
    .a(a8), .b(b8), .busy(busy8), .done(done8), .q(q8), .r(r8), .div_zero(dz8)
  );

  always #5 clock = ~clock;

  always @(posedge clock) edgeCnt <= edgeCnt + 1;

  function automatic logic [64:0] refDiv(input logic sm, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy;
    logic [31:0] rq, rr;
    if (y == 0) return {32'hFFFFFFFF, x, 1'b1};
    if (sm) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      rq = 32'(sx / sy);
      rr = 32'(sx % sy);
    end else begin
      rq = x / y;
      rr = x % y;
    end
    return {rq, rr, 1'b0};
  endfunction

  // Model: idle accepts start, result appears after a fixed number of edges, busy meanwhile.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mBusy <= 1'b0;
      mDone <= 1'b0;
      mQ    <= '0;
      mR    <= '0;
      mDz   <= 1'b0;
      mLeft <= 0;
    end else begin
      mDone <= 1'b0;
      if (mBusy) begin
        mLeft <= mLeft - 1;
        if (mLeft == 1) begin
          mBusy <= 1'b0;
          mDone <= 1'b1;
          {mQ, mR, mDz} <= pending;
        end
      end else if (start) begin
        pending <= refDiv(signed_mode, a, b);
        mBusy   <= 1'b1;
        mLeft   <= (b == 0) ? 1 : W + 1;
      end
    end
  end

  always @(negedge clock) begin
    if (reset_n && checkEn) begin
      vecCount++;
      if ({busy, done, q, r, div_zero} !== {mBusy, mDone, mQ, mR, mDz}) begin
        missCount++;
        $display("[TB] FAIL cycle-model @edge %0d: busy/done/q/r/dz got %b/%b/%h/%h/%b, expected %b/%b/%h/%h/%b",
                 edgeCnt, busy, done, q, r, div_zero, mBusy, mDone, mQ, mR, mDz);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Called just after a falling edge; start is sampled on the next rising edge.
  task automatic applyStimulus(input logic sm, input logic [31:0] x, input logic [31:0] y);
    start       = 1'b1;
    signed_mode = sm;
    a           = x;
    b           = y;
    @(negedge clock);
    startEdge = edgeCnt;
    start     = 1'b0;
  endtask

  task automatic waitDone(input string name, input int expLat);
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!done && n < 200);
    checkOutput({name, " latency"}, 128'(edgeCnt - startEdge), 128'(expLat));
  endtask

  task automatic directed(input string name, input logic sm, input logic [31:0] x, input logic [31:0] y,
                          input int lat, input logic [31:0] eq, input logic [31:0] er, input logic edz);
    applyStimulus(sm, x, y);
    waitDone(name, lat);
    checkOutput({name, " q"}, 128'(q), 128'(eq));
    checkOutput({name, " r"}, 128'(r), 128'(er));
    checkOutput({name, " div_zero"}, 128'(div_zero), 128'(edz));
  endtask

  task automatic run8(input string name, input logic sm, input logic [7:0] x, input logic [7:0] y,
                      input int lat, input logic [7:0] eq, input logic [7:0] er, input logic edz);
    int s;
    int n = 0;
    start8 = 1'b1;
    sm8    = sm;
    a8     = x;
    b8     = y;
    @(negedge clock);
    s      = edgeCnt;
    start8 = 1'b0;
    do begin
      @(negedge clock);
      n++;
    end while (!done8 && n < 50);
    checkOutput({name, " latency"}, 128'(edgeCnt - s), 128'(lat));
    checkOutput({name, " q"}, 128'(q8), 128'(eq));
    checkOutput({name, " r"}, 128'(r8), 128'(er));
    checkOutput({name, " div_zero"}, 128'(dz8), 128'(edz));
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] x, y;
    logic sm;
    int off;

    repeat (2) @(negedge clock);
    checkOutput("reset outputs", 128'({busy, done, q, r, div_zero}), 128'(0));
    reset_n = 1'b1;
    checkEn = 1'b1;
    @(negedge clock);

    directed("u 19/5", 1'b0, 32'd19, 32'd5, 33, 32'd3, 32'd4, 1'b0);
    directed("u 7/3", 1'b0, 32'd7, 32'd3, 33, 32'd2, 32'd1, 1'b0);
    directed("u 63/17", 1'b0, 32'd63, 32'd17, 33, 32'd3, 32'd12, 1'b0);
    directed("s -7/2", 1'b1, 32'hFFFFFFF9, 32'd2, 33, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0);
    directed("s 7/-2", 1'b1, 32'd7, 32'hFFFFFFFE, 33, 32'hFFFFFFFD, 32'd1, 1'b0);
    directed("u 27/0", 1'b0, 32'd27, 32'd0, 1, 32'hFFFFFFFF, 32'd27, 1'b1);
    directed("s 27/0", 1'b1, 32'd27, 32'd0, 1, 32'hFFFFFFFF, 32'd27, 1'b1);
    directed("s min/-1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 33, 32'h80000000, 32'd0, 1'b0);

    // A start pulse while busy must be ignored; a start in the done cycle must be taken.
    applyStimulus(1'b0, 32'd48, 32'd7);
    repeat (9) @(negedge clock);
    start = 1'b1;
    a     = 32'd1;
    b     = 32'd1;
    @(negedge clock);
    start = 1'b0;
    waitDone("u 48/7 busy-start", 33);
    checkOutput("u 48/7 q", 128'(q), 128'(32'd6));
    checkOutput("u 48/7 r", 128'(r), 128'(32'd6));
    directed("u 12/12 in done cycle", 1'b0, 32'd12, 32'd12, 33, 32'd1, 32'd0, 1'b0);

    applyStimulus(1'b0, 32'd27, 32'd11);
    repeat (14) @(negedge clock);
    @(posedge clock);
    #1 reset_n = 1'b0;
    #1 checkOutput("async reset outputs", 128'({busy, done, q, r, div_zero}), 128'(0));
    @(negedge clock);
    reset_n = 1'b1;
    directed("u 27/11 after reset", 1'b0, 32'd27, 32'd11, 33, 32'd2, 32'd5, 1'b0);

    run8("w8 s 0x80/0xFF", 1'b1, 8'h80, 8'hFF, 9, 8'h80, 8'h00, 1'b0);
    run8("w8 u 200/7", 1'b0, 8'd200, 8'd7, 9, 8'd28, 8'd4, 1'b0);
    run8("w8 s -7/2", 1'b1, 8'hF9, 8'h02, 9, 8'hFD, 8'hFF, 1'b0);
    run8("w8 s 0x80/0", 1'b1, 8'h80, 8'h00, 1, 8'hFF, 8'h80, 1'b1);

    for (int i = 0; i < 60; i++) begin
      sm = 1'($urandom_range(0, 1));
      x  = $urandom;
      case ($urandom_range(0, 5))
        0: y = 32'd0;
        1: y = 32'($urandom_range(1, 20));
        2: y = 32'hFFFFFFFF;
        3: begin x = 32'h80000000; y = (($urandom & 1) != 0) ? 32'hFFFFFFFF : $urandom; end
        4: y = x;
        default: y = $urandom;
      endcase
      repeat ($urandom_range(0, 2)) @(negedge clock);
      applyStimulus(sm, x, y);
      if (y != 0 && $urandom_range(0, 1) == 1) begin
        off = $urandom_range(0, 30);
        repeat (off) @(negedge clock);
        start = 1'b1;
        a     = $urandom;
        b     = $urandom;
        @(negedge clock);
        start = 1'b0;
      end
      waitDone("random", (y == 0) ? 1 : 33);
    end

    repeat (3) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule

// File: doc/divider_seq.md
DIVIDER_SEQ -- requirements
Module: divider_seq

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand/result width in bits (legal range >= 2).
REQ-002 SHALL have port: clock  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: start  input  1  request; sampled on rising clock edge.
REQ-005 SHALL have port: signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
REQ-006 SHALL have port: a  input  WIDTH  dividend; sampled with start.
REQ-007 SHALL have port: b  input  WIDTH  divisor; sampled with start.
REQ-008 SHALL have port: busy  output  1  operation in progress.
REQ-009 SHALL have port: done  output  1  one-cycle completion pulse.
REQ-010 SHALL have port: q  output  WIDTH  quotient, registered.
REQ-011 SHALL have port: r  output  WIDTH  remainder, registered.
REQ-012 SHALL have port: div_zero  output  1  last completed operation had b == 0.

Function
REQ-013 SHALL implement states IDLE, RUN, FIX; IDLE after reset.
REQ-014 SHALL accept start only in IDLE, including the cycle in which done is high; start in RUN/FIX SHALL be ignored.
REQ-015 On accepting edge k, SHALL latch a, b, signed_mode, store magnitudes (abs value when signed_mode=1, raw otherwise), record result signs, set busy=1, and go to RUN with iteration counter = WIDTH.
REQ-016 In RUN, SHALL perform one restoring-division step per edge (shift remainder left with next dividend MSB, subtract divisor magnitude if no borrow, set quotient bit), WIDTH steps total, then go to FIX.
REQ-017 Internal remainder/subtract path SHALL be WIDTH+1 bits so magnitude 2^(WIDTH-1) is handled without overflow.
REQ-018 On the FIX edge, SHALL apply sign correction, write q, r, div_zero, assert done for exactly one cycle, deassert busy, and return to IDLE.
REQ-019 Latency for b != 0 SHALL be fixed: done high in the cycle following edge k+WIDTH+1; busy high from edge k until edge k+WIDTH+1.
REQ-020 Signed mode: quotient negated iff dividend and divisor signs differ; remainder takes the dividend's sign (truncating division); |r| < |b|.
REQ-021 Signed overflow (most-negative / -1) SHALL give q = most-negative value, r = 0, div_zero = 0.
REQ-022 b == 0 SHALL bypass RUN: accepting edge goes directly to FIX; done high after edge k+1; q = all ones, r = original a, div_zero = 1, in both modes.
REQ-023 q, r, div_zero SHALL change only on FIX edges and hold otherwise.

Reset
REQ-024 reset_n low SHALL immediately force state IDLE, busy=0, done=0, q=0, r=0, div_zero=0, counter=0, regardless of clock or operation in progress.
REQ-025 After reset_n rises, the first rising edge with start=1 SHALL be accepted normally; no partial result from an aborted operation SHALL ever appear.

Verification
REQ-026 WIDTH=32, unsigned, a=19, b=5, start pulsed at edge k -> done high only after edge k+33, q=3, r=4, div_zero=0; also 7/3 -> 2 R 1, 63/17 -> 3 R 12.
REQ-027 WIDTH=32, signed, a=-7, b=2 -> q=0xFFFFFFFD, r=0xFFFFFFFF; a=7, b=-2 -> q=0xFFFFFFFD, r=1.
REQ-028 WIDTH=8, signed, a=0x80, b=0xFF -> q=0x80, r=0x00, div_zero=0, done after edge k+9.
REQ-029 WIDTH=32, a=27, b=0 (both modes) -> done after edge k+1, q=0xFFFFFFFF, r=27, div_zero=1.
REQ-030 Start 48/7 unsigned, pulse start with 1/1 at edge k+10 -> ignored, result q=6, r=6; start 12/12 in the done cycle -> accepted, q=1, r=0 after WIDTH+1 further edges.
REQ-031 Assert reset_n low at edge k+15 of a 27/11 run -> busy, done, q, r, div_zero 0 immediately; after release, 27/11 -> q=2, r=5 with full latency.
